// File: rtl/crc_pkg.sv
// Shared definitions for the streaming CRC blocks (encoder now, checker later).
// FSM encoding and the standard polynomials used to configure them.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        CRC_OUT = 2'd2
    } state_e;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [7:0]  CRC8_POLY        = 8'h07;

endpackage

// File: rtl/crc_param_gen_if.sv
// Payload-in / stream-out bundle for the CRC encoder.
// master = frame source side, slave = encoder side.
interface crc_param_gen_if #(
    parameter int DIN_W = 1,
    parameter int CRC_W = 16
);
    logic             i_start;
    logic             i_valid;
    logic [DIN_W-1:0] i_data;
    logic             o_ready;
    logic             o_valid;
    logic [DIN_W-1:0] o_data;
    logic [CRC_W-1:0] o_crc_code;
    logic             o_crc_done;
    logic             o_busy;
    logic             o_err;

    modport master (
        output i_start, i_valid, i_data,
        input  o_ready, o_valid, o_data, o_crc_code, o_crc_done, o_busy, o_err
    );

    modport slave (
        input  i_start, i_valid, i_data,
        output o_ready, o_valid, o_data, o_crc_code, o_crc_done, o_busy, o_err
    );
endinterface

// File: rtl/crc_step.sv
// Advances an MSB-first, non-reflected CRC register by DIN_W input bits.
// Purely combinational; bit DIN_W-1 of din is consumed first.
module crc_step #(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = 16'h1021,
    parameter int               DIN_W = 1
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [DIN_W-1:0] din,
    output logic [CRC_W-1:0] crc_out
);
    logic [CRC_W-1:0] acc;

    always_comb begin
        acc = crc_in;
        for (int i = DIN_W - 1; i >= 0; i--) begin
            if (din[i] ^ acc[CRC_W-1]) begin
                acc = (acc << 1) ^ POLY;
            end else begin
                acc = acc << 1;
            end
        end
        crc_out = acc;
    end
endmodule

// File: rtl/crc_param_gen.sv
// Streaming CRC encoder: forwards FRAME_LEN payload bits, then appends the CRC MSB chunk first.
// Latency: 1 cycle input beat to output beat; CRC beats follow the last payload beat back to back.
// Backpressure: none downstream; upstream sees o_ready only in DATA, gaps simply stall the frame.
module crc_param_gen
    import crc_pkg::*;
#(
    parameter int               CRC_W     = 16,
    parameter logic [CRC_W-1:0] POLY      = CRC16_CCITT_POLY,
    parameter logic [CRC_W-1:0] INIT      = '0,
    parameter int               DIN_W     = 1,
    parameter int               FRAME_LEN = 32
) (
    input logic            i_clk,
    input logic            i_rst_n,
    crc_param_gen_if.slave bus
);
    localparam int BEATS     = FRAME_LEN / DIN_W;
    localparam int CRC_BEATS = CRC_W / DIN_W;
    localparam int BCNT_W    = $clog2(BEATS + 1);
    localparam int CCNT_W    = $clog2(CRC_BEATS + 1);

    if ((CRC_W % DIN_W) != 0 || (FRAME_LEN % DIN_W) != 0 || FRAME_LEN < DIN_W) begin : g_bad_params
        $fatal(1, "crc_param_gen: CRC_W and FRAME_LEN must be non-zero multiples of DIN_W");
    end

    state_e             state_q, state_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [CCNT_W-1:0]  ccnt_q, ccnt_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CRC_W-1:0]   sh_q, sh_d;
    logic [DIN_W-1:0]   odat_q, odat_d;
    logic               ovld_q, ovld_d;
    logic [CRC_W-1:0]   code_q, code_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CRC_W-1:0]   crc_nxt;

    crc_step #(.CRC_W(CRC_W), .POLY(POLY), .DIN_W(DIN_W)) u_step (
        .crc_in  (crc_q),
        .din     (bus.i_data),
        .crc_out (crc_nxt)
    );

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        ccnt_d  = ccnt_q;
        crc_d   = crc_q;
        sh_d    = sh_q;
        odat_d  = odat_q;
        ovld_d  = 1'b0;
        code_d  = code_q;
        done_d  = 1'b0;
        err_d   = bus.i_start && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = DATA;
                    crc_d   = INIT;
                    bcnt_d  = '0;
                end
            end
            DATA: begin
                if (bus.i_valid) begin
                    crc_d  = crc_nxt;
                    odat_d = bus.i_data;
                    ovld_d = 1'b1;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == BCNT_W'(BEATS - 1)) begin
                        state_d = CRC_OUT;
                        sh_d    = crc_nxt;
                        ccnt_d  = '0;
                    end
                end
            end
            CRC_OUT: begin
                // Stay one extra cycle so the state still reads CRC_OUT while the last chunk is on o_data.
                if (ccnt_q == CCNT_W'(CRC_BEATS)) begin
                    state_d = IDLE;
                end else begin
                    odat_d = sh_q[CRC_W-1 -: DIN_W];
                    ovld_d = 1'b1;
                    sh_d   = sh_q << DIN_W;
                    ccnt_d = ccnt_q + 1'b1;
                    if (ccnt_q == CCNT_W'(CRC_BEATS - 1)) begin
                        done_d = 1'b1;
                        code_d = crc_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            ccnt_q  <= '0;
            crc_q   <= INIT;
            sh_q    <= '0;
            odat_q  <= '0;
            ovld_q  <= 1'b0;
            code_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            ccnt_q  <= ccnt_d;
            crc_q   <= crc_d;
            sh_q    <= sh_d;
            odat_q  <= odat_d;
            ovld_q  <= ovld_d;
            code_q  <= code_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_ready    = (state_q == DATA);
    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_valid    = ovld_q;
    assign bus.o_data     = odat_q;
    assign bus.o_crc_code = code_q;
    assign bus.o_crc_done = done_q;
    assign bus.o_err      = err_q;
endmodule

// File: tb/tb_crc_param_gen.sv
// Drives four encoder configurations with known and random frames and checks them
// against a polynomial long-division model of the CRC.
module tb_crc_param_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    crc_param_gen_if #(.DIN_W(8), .CRC_W(16)) if8a (), if8b ();
    crc_param_gen_if #(.DIN_W(1), .CRC_W(16)) if1a (), if1b ();

    logic       st8, vld8, st1a, st1b, vld1, dat1;
    logic [7:0] dat8;
    assign if8a.i_start = st8;  assign if8a.i_valid = vld8; assign if8a.i_data = dat8;
    assign if8b.i_start = st8;  assign if8b.i_valid = vld8; assign if8b.i_data = dat8;
    assign if1a.i_start = st1a; assign if1a.i_valid = vld1; assign if1a.i_data = dat1;
    assign if1b.i_start = st1b; assign if1b.i_valid = vld1; assign if1b.i_data = dat1;

    crc_param_gen #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .DIN_W(8), .FRAME_LEN(72))
        u_8a (.i_clk(clk), .i_rst_n(rst_n), .bus(if8a));
    crc_param_gen #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .DIN_W(8), .FRAME_LEN(72))
        u_8b (.i_clk(clk), .i_rst_n(rst_n), .bus(if8b));
    crc_param_gen #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .DIN_W(1), .FRAME_LEN(72))
        u_1a (.i_clk(clk), .i_rst_n(rst_n), .bus(if1a));
    crc_param_gen #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .DIN_W(1), .FRAME_LEN(32))
        u_1b (.i_clk(clk), .i_rst_n(rst_n), .bus(if1b));

    logic [31:0] o8a_all, o8b_all, o1a_all, o1b_all;
    assign o8a_all = {3'b0, if8a.o_valid, if8a.o_ready, if8a.o_busy, if8a.o_err, if8a.o_crc_done, if8a.o_data, if8a.o_crc_code};
    assign o8b_all = {3'b0, if8b.o_valid, if8b.o_ready, if8b.o_busy, if8b.o_err, if8b.o_crc_done, if8b.o_data, if8b.o_crc_code};
    assign o1a_all = {10'b0, if1a.o_valid, if1a.o_ready, if1a.o_busy, if1a.o_err, if1a.o_crc_done, if1a.o_data, if1a.o_crc_code};
    assign o1b_all = {10'b0, if1b.o_valid, if1b.o_ready, if1b.o_busy, if1b.o_err, if1b.o_crc_done, if1b.o_data, if1b.o_crc_code};

    localparam logic [15:0] POLY_REF = 16'h1021;

    bit          pay [0:127];
    bit          obits [0:3][0:4095];
    int          ocnt [4];
    int          dcnt [4];
    int          ecnt [4];
    int          done_cyc [4];
    logic [15:0] dcode [4];
    bit          vhist [0:8191];
    int          cyc;
    bit          vexp [0:511];
    int          vexplen;
    int          ob_s [4];
    int          db_s [4];
    int          eb_s [4];
    int          cyc_s;
    int          nvec, nerr;
    logic [1:0]  stat8;
    logic [15:0] hold8;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: collects every emitted bit in line order, plus done/err pulses.
    function automatic void mon(input int id, input logic vld, input logic [7:0] dat, input int w,
                                input logic done, input logic err, input logic [15:0] code);
        if (vld === 1'b1) begin
            for (int b = w - 1; b >= 0; b--) begin
                if (ocnt[id] < 4096) obits[id][ocnt[id]] = dat[b];
                ocnt[id]++;
            end
        end
        if (done === 1'b1) begin
            dcnt[id]++;
            dcode[id] = code;
            done_cyc[id] = cyc;
        end
        if (err === 1'b1) ecnt[id]++;
    endfunction

    always @(negedge clk) begin
        mon(0, if8a.o_valid, if8a.o_data, 8, if8a.o_crc_done, if8a.o_err, if8a.o_crc_code);
        mon(1, if8b.o_valid, if8b.o_data, 8, if8b.o_crc_done, if8b.o_err, if8b.o_crc_code);
        mon(2, if1a.o_valid, {7'b0, if1a.o_data}, 1, if1a.o_crc_done, if1a.o_err, if1a.o_crc_code);
        mon(3, if1b.o_valid, {7'b0, if1b.o_data}, 1, if1b.o_crc_done, if1b.o_err, if1b.o_crc_code);
        vhist[cyc % 8192] = if1a.o_valid;
        cyc++;
    end

    // Remainder of (M + INIT*x^(n-16)) * x^16 divided by x^16 + POLY, by long division.
    function automatic logic [15:0] ref_crc(input int n, input logic [15:0] init);
        bit          m [0:159];
        logic [15:0] r;
        for (int i = 0; i < n + 16; i++) m[i] = (i < n) ? pay[i] : 1'b0;
        for (int i = 0; i < 16; i++) m[i] = m[i] ^ init[15-i];
        for (int i = 0; i < n; i++)
            if (m[i]) for (int j = 1; j <= 16; j++) m[i+j] = m[i+j] ^ POLY_REF[16-j];
        for (int k = 0; k < 16; k++) r[15-k] = m[n+k];
        return r;
    endfunction

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            c = s[i];
            for (int b = 0; b < 8; b++) pay[i*8+b] = c[7-b];
        end
    endtask

    task automatic rand_pay();
        for (int i = 0; i < 128; i++) pay[i] = 1'($urandom);
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) begin
            ob_s[i] = ocnt[i];
            db_s[i] = dcnt[i];
            eb_s[i] = ecnt[i];
        end
        cyc_s = cyc;
    endtask

    task automatic send8(input int nb, input int gap_pct, input int err_at);
        @(posedge clk); #1;
        st8 = 1'b1; vld8 = 1'b1; dat8 = 8'($urandom);
        @(posedge clk); #1;
        st8 = 1'b0;
        stat8 = {if8a.o_ready, if8a.o_busy};
        hold8 = if8a.o_crc_code;
        for (int i = 0; i < nb; i++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
                vld8 = 1'b0;
                @(posedge clk); #1;
            end
            vld8 = 1'b1;
            for (int b = 0; b < 8; b++) dat8[7-b] = pay[i*8+b];
            st8 = (i == err_at);
            @(posedge clk); #1;
            st8 = 1'b0;
        end
        vld8 = 1'b0;
    endtask

    task automatic send1(input int id, input int plen, input int gap_pct);
        vexplen = 0;
        @(posedge clk); #1;
        if (id == 2) st1a = 1'b1; else st1b = 1'b1;
        vld1 = 1'b1; dat1 = 1'($urandom);
        @(posedge clk); #1;
        st1a = 1'b0; st1b = 1'b0;
        for (int i = 0; i < plen; i++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
                vld1 = 1'b0;
                if (i > 0) begin vexp[vexplen] = 1'b0; vexplen++; end
                @(posedge clk); #1;
            end
            vld1 = 1'b1; dat1 = pay[i];
            vexp[vexplen] = 1'b1; vexplen++;
            @(posedge clk); #1;
        end
        vld1 = 1'b0;
        for (int i = 0; i < 16; i++) begin vexp[vexplen] = 1'b1; vexplen++; end
    endtask

    task automatic wait_done(input int id, input int budget);
        for (int k = 0; k < budget && dcnt[id] == db_s[id]; k++) begin
            @(negedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int id, input int plen, input logic [15:0] init,
                               input int exp_err, input string tag);
        logic [15:0] r;
        int          bad;
        bit          e;
        r = ref_crc(plen, init);
        bad = 0;
        chk({tag, ":len"}, ocnt[id] - ob_s[id], plen + 16);
        for (int i = 0; i < plen + 16; i++) begin
            e = (i < plen) ? pay[i] : r[15-(i-plen)];
            if (ob_s[id] + i >= 4096 || obits[id][ob_s[id]+i] != e) bad++;
        end
        chk({tag, ":bad_bits"}, bad, 0);
        chk({tag, ":code"}, dcode[id], r);
        chk({tag, ":done_pulses"}, dcnt[id] - db_s[id], 1);
        chk({tag, ":err_pulses"}, ecnt[id] - eb_s[id], exp_err);
    endtask

    // o_valid of the DIN_W=1 encoder from its first high cycle to the done cycle must track accepted beats.
    task automatic check_vld(input string tag);
        int f, n, bad;
        f = -1;
        for (int c = cyc_s; c <= done_cyc[2]; c++) if (f < 0 && vhist[c % 8192]) f = c;
        n = (f < 0) ? 0 : done_cyc[2] - f + 1;
        chk({tag, ":vld_len"}, n, vexplen);
        bad = 0;
        for (int i = 0; i < n && i < vexplen; i++) if (vhist[(f+i) % 8192] != vexp[i]) bad++;
        chk({tag, ":vld_bad"}, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1);
    end

    initial begin
        st8 = 0; vld8 = 0; dat8 = 0; st1a = 0; st1b = 0; vld1 = 0; dat1 = 0;
        nvec = 0; nerr = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst:8a", o8a_all, 0);
        chk("rst:8b", o8b_all, 0);
        chk("rst:1a", o1a_all, 0);
        chk("rst:1b", o1b_all, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // valid without start is ignored while idle
        snap();
        vld8 = 1'b1; vld1 = 1'b1; dat8 = 8'hA5;
        repeat (4) @(posedge clk);
        #1;
        vld8 = 1'b0; vld1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle:no_out8", ocnt[0] - ob_s[0], 0);
        chk("idle:no_out1", ocnt[2] - ob_s[2], 0);

        // check value frames, both INIT values
        load_str("123456789");
        snap();
        send8(9, 0, -1);
        wait_done(0, 100);
        chk("s1:rdy_busy", stat8, 2'b11);
        check_frame(0, 72, 16'h0000, 0, "s1");
        check_frame(1, 72, 16'hFFFF, 0, "s2");
        chk("s1:xmodem", dcode[0], 16'h31C3);
        chk("s2:ccitt_false", dcode[1], 16'h29B1);
        chk("s1:idle_rdy_busy", {if8a.o_ready, if8a.o_busy}, 2'b00);

        // start mid-frame: flagged, frame unaffected; previous code held through the new start
        snap();
        send8(9, 0, 4);
        wait_done(0, 100);
        chk("s5:code_hold", hold8, 16'h31C3);
        check_frame(0, 72, 16'h0000, 1, "s5");
        check_frame(1, 72, 16'hFFFF, 1, "s5b");

        // start on the last CRC beat is rejected
        rand_pay();
        snap();
        send8(9, 0, -1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("s7:done_now", if8a.o_crc_done, 1'b1);
        st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        @(negedge clk); #1;
        chk("s7:err", ecnt[0] - eb_s[0], 1);
        chk("s7:not_busy", if8a.o_busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_frame(0, 72, 16'h0000, 1, "s7");

        // reset mid-frame, then a full frame
        rand_pay();
        send8(4, 0, -1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("s6:rst_8a", o8a_all, 0);
        chk("s6:rst_8b", o8b_all, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rand_pay();
        snap();
        send8(9, 25, -1);
        wait_done(0, 200);
        check_frame(0, 72, 16'h0000, 0, "s6");
        check_frame(1, 72, 16'hFFFF, 0, "s6b");

        for (int r = 0; r < 4; r++) begin
            rand_pay();
            snap();
            send8(9, 20, -1);
            wait_done(0, 200);
            check_frame(0, 72, 16'h0000, 0, $sformatf("r8a_%0d", r));
            check_frame(1, 72, 16'hFFFF, 0, $sformatf("r8b_%0d", r));
        end

        // serial frame with random gaps
        load_str("123456789");
        snap();
        send1(2, 72, 30);
        wait_done(2, 600);
        check_frame(2, 72, 16'h0000, 0, "s3");
        chk("s3:xmodem", dcode[2], 16'h31C3);
        check_vld("s3");

        for (int r = 0; r < 2; r++) begin
            rand_pay();
            snap();
            send1(2, 72, 25);
            wait_done(2, 600);
            check_frame(2, 72, 16'h0000, 0, $sformatf("r1a_%0d", r));
            check_vld($sformatf("r1a_%0d", r));
        end

        // all-zero short frame
        for (int i = 0; i < 128; i++) pay[i] = 1'b0;
        snap();
        send1(3, 32, 0);
        wait_done(3, 200);
        check_frame(3, 32, 16'h0000, 0, "s4");
        chk("s4:zero_code", dcode[3], 16'h0000);

        for (int r = 0; r < 2; r++) begin
            rand_pay();
            snap();
            send1(3, 32, 20);
            wait_done(3, 300);
            check_frame(3, 32, 16'h0000, 0, $sformatf("r1b_%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
